// File: rtl/unidad_procesadora_pipe.sv
// Two-stage processing unit: register file, ALU and shifter behind a valid/ready input.
// Define UP_FORWARD_EN to bypass read-after-write hazards instead of stalling for one cycle.
module unidad_procesadora_pipe #(
  parameter int W = 8,
  parameter int R = 8,
  localparam int AW = $clog2(R),
  localparam int CW = 3*AW+7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] ctrl_word,
  input  logic [W-1:0]  data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  data_out,
  output logic          out_valid,
  output logic [3:0]    state_bits
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready may look at ctrl_word, in_valid must never look at in_ready.

  logic [AW-1:0] in_a, in_b, in_d;
  logic [3:0]    in_alu;
  logic [2:0]    in_sh;

  assign in_a   = ctrl_word[CW-1 -: AW];
  assign in_b   = ctrl_word[CW-1-AW -: AW];
  assign in_d   = ctrl_word[CW-1-2*AW -: AW];
  assign in_alu = ctrl_word[6:3];
  assign in_sh  = ctrl_word[2:0];

  // Entry 0 is never written; address 0 selects data_in instead.
  logic [W-1:0] regs [R];

  logic          s1_valid;
  logic [AW-1:0] s1_d;
  logic [3:0]    s1_alu;
  logic [2:0]    s1_sh;
  logic [W-1:0]  s1_opa, s1_opb;

  logic          hazard_a, hazard_b;
  logic          accept;
  logic [W-1:0]  opa_next, opb_next;

  logic [W-1:0]  y;
  logic [W:0]    sum;
  logic [W-1:0]  alu_res;
  logic [W-1:0]  sh_res;
  logic          arith;
  logic          flag_v, flag_n, flag_z, flag_c;

  assign hazard_a = s1_valid && (s1_d != '0) && (in_a != '0) && (in_a == s1_d);
  assign hazard_b = s1_valid && (s1_d != '0) && (in_b != '0) && (in_b == s1_d);

`ifdef UP_FORWARD_EN
  assign in_ready = !reset;

  always_comb begin
    opa_next = data_in;
    opb_next = data_in;
    if (hazard_a)         opa_next = sh_res;
    else if (in_a != '0)  opa_next = regs[in_a];
    if (hazard_b)         opb_next = sh_res;
    else if (in_b != '0)  opb_next = regs[in_b];
  end
`else
  // A dependent word waits one cycle so it reads the freshly written register.
  assign in_ready = !reset && !(hazard_a || hazard_b);

  always_comb begin
    opa_next = data_in;
    opb_next = data_in;
    if (in_a != '0) opa_next = regs[in_a];
    if (in_b != '0) opb_next = regs[in_b];
  end
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_alu   <= '0;
      s1_sh    <= '0;
      s1_opa   <= '0;
      s1_opb   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_d   <= in_d;
        s1_alu <= in_alu;
        s1_sh  <= in_sh;
        s1_opa <= opa_next;
        s1_opb <= opb_next;
      end
    end
  end

  always_comb begin
    unique case (s1_alu[2:1])
      2'b00:   y = '0;
      2'b01:   y = s1_opb;
      2'b10:   y = ~s1_opb;
      default: y = '1;
    endcase
    arith = !s1_alu[3];
    sum   = {1'b0, s1_opa} + {1'b0, y} + {{W{1'b0}}, s1_alu[0]};
    if (arith) begin
      alu_res = sum[W-1:0];
    end else begin
      unique case (s1_alu[2:1])
        2'b00:   alu_res = s1_opa & s1_opb;
        2'b01:   alu_res = s1_opa | s1_opb;
        2'b10:   alu_res = s1_opa ^ s1_opb;
        default: alu_res = ~s1_opa;
      endcase
    end
  end

  // Flags describe the ALU result, not the shifted value.
  assign flag_n = alu_res[W-1];
  assign flag_z = (alu_res == '0);
  assign flag_c = arith && sum[W];
  assign flag_v = arith && (s1_opa[W-1] == y[W-1]) && (sum[W-1] != s1_opa[W-1]);

  always_comb begin
    unique case (s1_sh)
      3'b001:  sh_res = {alu_res[W-2:0], 1'b0};
      3'b010:  sh_res = {1'b0, alu_res[W-1:1]};
      3'b011:  sh_res = '0;
      3'b101:  sh_res = {alu_res[W-2:0], alu_res[W-1]};
      3'b110:  sh_res = {alu_res[0], alu_res[W-1:1]};
      default: sh_res = alu_res;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < R; i++) regs[i] <= '0;
    end else if (s1_valid && (s1_d != '0)) begin
      regs[s1_d] <= sh_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      state_bits <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= sh_res;
        state_bits <= {flag_v, flag_n, flag_z, flag_c};
      end
    end
  end

endmodule

// File: tb/tb_unidad_procesadora_pipe.sv
// Scoreboard bench for unidad_procesadora_pipe; expectations come from a sequential register model.
module tb_unidad_procesadora_pipe;
  localparam int W  = 8;
  localparam int R  = 8;
  localparam int AW = 3;
  localparam int CW = 3*AW+7;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] ctrl_word;
  logic [W-1:0]  data_in;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic [3:0]    state_bits;

  unidad_procesadora_pipe #(.W(W), .R(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_word  (ctrl_word),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .state_bits (state_bits)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_out = 0;
  int last_out = 0;
  int prev_out = 0;
  int last_stalls = 0;
  logic [W+3:0] exp_q[$];
  logic [W-1:0] mregs [R];

  always @(posedge clk) cyc++;

  // Scoreboard: every out_valid cycle must match the oldest expected {flags, data}.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      logic [W+3:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got flags=%b data=%h, no result expected", state_bits, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({state_bits, data_out} !== e) begin
          bad++;
          $display("FAIL result: got flags=%b data=%h, want flags=%b data=%h",
                   state_bits, data_out, e[W+3:W], e[W-1:0]);
        end
      end
      prev_out = last_out;
      last_out = cyc;
      n_out++;
    end
  end

  function automatic logic [W+3:0] model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                         input logic [3:0] alu, input logic [2:0] sh);
    logic [W-1:0] y, r, s;
    logic [W:0]   t;
    logic         c, v;
    case (alu[2:1])
      2'd0:    y = '0;
      2'd1:    y = b_v;
      2'd2:    y = ~b_v;
      default: y = '1;
    endcase
    if (!alu[3]) begin
      t = a_v + y + alu[0];
      r = t[W-1:0];
      c = t[W];
      v = (a_v[W-1] == y[W-1]) && (r[W-1] != a_v[W-1]);
    end else begin
      c = 1'b0;
      v = 1'b0;
      case (alu[2:1])
        2'd0:    r = a_v & b_v;
        2'd1:    r = a_v | b_v;
        2'd2:    r = a_v ^ b_v;
        default: r = ~a_v;
      endcase
    end
    case (sh)
      3'b001:  s = r << 1;
      3'b010:  s = r >> 1;
      3'b011:  s = '0;
      3'b101:  s = {r[W-2:0], r[W-1]};
      3'b110:  s = {r[0], r[W-1:1]};
      default: s = r;
    endcase
    return {v, r[W-1], (r == '0), c, s};
  endfunction

  // Called at #1 after a rising edge; returns #1 after the accept edge with in_valid still high.
  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                      input logic [3:0] alu, input logic [2:0] sh, input logic [W-1:0] din);
    logic ok;
    logic [W-1:0] a_v, b_v;
    logic [W+3:0] e;
    ctrl_word = {a, b, d, alu, sh};
    data_in   = din;
    in_valid  = 1'b1;
    ok = 1'b0;
    last_stalls = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else last_stalls++;
      @(posedge clk);
      #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: in_ready stayed %b, want 1 within 8 cycles", in_ready);
    end else begin
      a_v = (a != '0) ? mregs[a] : din;
      b_v = (b != '0) ? mregs[b] : din;
      e = model(a_v, b_v, alu, sh);
      exp_q.push_back(e);
      if (d != '0) mregs[d] = e[W-1:0];
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    ctrl_word = '0;
    data_in = '0;
    for (int i = 0; i < R; i++) mregs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 3;
    if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    if (state_bits !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", state_bits); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
    @(posedge clk);
    #1;

    // Reset mid-stream: one result on the outputs, a second word sitting in S1.
    send(3'd0, 3'd0, 3'd1, 4'b0000, 3'b000, 8'h5A);
    send(3'd0, 3'd0, 3'd2, 4'b0000, 3'b000, 8'h33);
    #6;
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    if (data_out !== 8'h5A) begin bad++; $display("FAIL pre_reset_data: got %h want 5a", data_out); end
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    total += 3;
    if (data_out !== '0) begin bad++; $display("FAIL async_reset_data: got %h want 00", data_out); end
    if (state_bits !== 4'b0000) begin bad++; $display("FAIL async_reset_flags: got %b want 0000", state_bits); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    exp_q.delete();
    for (int i = 0; i < R; i++) mregs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    send(3'd1, 3'd1, 3'd0, 4'b0010, 3'b000, 8'($urandom_range(0, 255)));
    drain();
    total += 2;
    if (data_out !== 8'h00) begin bad++; $display("FAIL zero_add_data: got %h want 00", data_out); end
    if (state_bits !== 4'b0010) begin bad++; $display("FAIL zero_add_flags: got %b want 0010", state_bits); end
  endtask

  task automatic test_load();
    send(3'd0, 3'd0, 3'd1, 4'b0000, 3'b000, 8'h5A);
    drain();
    total += 2;
    if (data_out !== 8'h5A) begin bad++; $display("FAIL load_data: got %h want 5a", data_out); end
    if (state_bits !== 4'b0000) begin bad++; $display("FAIL load_flags: got %b want 0000", state_bits); end
    send(3'd1, 3'd0, 3'd0, 4'b0000, 3'b000, 8'($urandom_range(0, 255)));
    drain();
  endtask

  task automatic test_overflow();
    send(3'd0, 3'd0, 3'd1, 4'b0000, 3'b000, 8'h7F);
    send(3'd1, 3'd0, 3'd0, 4'b0010, 3'b000, 8'h01);
    drain();
    total += 2;
    if (data_out !== 8'h80) begin bad++; $display("FAIL ovf_data: got %h want 80", data_out); end
    if (state_bits !== 4'b1100) begin bad++; $display("FAIL ovf_flags: got %b want 1100", state_bits); end
    send(3'd1, 3'd0, 3'd0, 4'b0100, 3'b000, 8'h7F);
    drain();
    total += 2;
    if (data_out !== 8'hFF) begin bad++; $display("FAIL sub_data: got %h want ff", data_out); end
    if (state_bits !== 4'b0100) begin bad++; $display("FAIL sub_flags: got %b want 0100", state_bits); end
  endtask

  task automatic test_shift();
    send(3'd0, 3'd0, 3'd2, 4'b0000, 3'b000, 8'h81);
    send(3'd2, 3'd0, 3'd0, 4'b0000, 3'b101, 8'h00);
    send(3'd2, 3'd0, 3'd0, 4'b0000, 3'b110, 8'h00);
    send(3'd2, 3'd0, 3'd0, 4'b0000, 3'b001, 8'h00);
    send(3'd2, 3'd0, 3'd0, 4'b0000, 3'b010, 8'h00);
    send(3'd2, 3'd0, 3'd0, 4'b0000, 3'b011, 8'h00);
    drain();
    total += 2;
    if (data_out !== 8'h00) begin bad++; $display("FAIL shift_zero_data: got %h want 00", data_out); end
    if (state_bits !== 4'b0100) begin bad++; $display("FAIL shift_zero_flags: got %b want 0100", state_bits); end
  endtask

  task automatic test_hazard();
    int exp_stalls, exp_gap;
`ifdef UP_FORWARD_EN
    exp_stalls = 0;
    exp_gap = 1;
`else
    exp_stalls = 1;
    exp_gap = 2;
`endif
    send(3'd0, 3'd0, 3'd3, 4'b0000, 3'b000, 8'h03);
    send(3'd3, 3'd3, 3'd4, 4'b0010, 3'b000, 8'hEE);
    drain();
    total += 3;
    if (last_stalls !== exp_stalls) begin
      bad++; $display("FAIL hazard_stall: got %0d stall cycles want %0d", last_stalls, exp_stalls);
    end
    if (last_out - prev_out !== exp_gap) begin
      bad++; $display("FAIL hazard_gap: got %0d cycles between results want %0d", last_out - prev_out, exp_gap);
    end
    if (data_out !== 8'h06) begin bad++; $display("FAIL hazard_data: got %h want 06", data_out); end
    send(3'd4, 3'd0, 3'd0, 4'b0000, 3'b000, 8'h00);
    drain();
  endtask

  task automatic test_write_r0();
    int n0;
    n0 = n_out;
    send(3'd0, 3'd0, 3'd0, 4'b0000, 3'b000, 8'h11);
    drain();
    total++;
    if (data_out !== 8'h11) begin bad++; $display("FAIL r0_data: got %h want 11", data_out); end
    send(3'd0, 3'd0, 3'd0, 4'b0000, 3'b000, 8'h22);
    for (int r = 1; r < R; r++) send(AW'(r), 3'd0, 3'd0, 4'b0000, 3'b000, 8'($urandom_range(0, 255)));
    drain();
    total++;
    if (n_out - n0 !== R + 1) begin bad++; $display("FAIL r0_count: got %0d results want %0d", n_out - n0, R + 1); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_out;
    for (int i = 0; i < 40; i++) begin
      send(AW'($urandom_range(0, R-1)), AW'($urandom_range(0, R-1)), AW'($urandom_range(0, R-1)),
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    drain();
    for (int r = 1; r < R; r++) send(AW'(r), 3'd0, 3'd0, 4'b0000, 3'b000, 8'h00);
    drain();
    total++;
    if (n_out - n0 !== 40 + R - 1) begin
      bad++; $display("FAIL b2b_count: got %0d results want %0d", n_out - n0, 40 + R - 1);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_shift();
    test_hazard();
    test_write_r0();
    test_back_to_back();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidad_procesadora_pipe.md
# unidad_procesadora_pipe

Parametrised, pipelined successor of the 4-bit processing unit. It holds a register file of `R` entries of `W` bits, an ALU and a shifter, and executes one control word per accepted handshake. Operands are captured in an execute stage, and results, register writeback and status flags are registered one clock later. It sits between the sequencer, which issues control words with a valid/ready handshake, and the data bus.

## Interface
- `W`, 8, data width; must be ≥ 2.
- `R`, 8, register-file entries; must be a power of 2 and ≥ 2. Address 0 is not a storage location: it selects `data_in`.
- `AW`, localparam `$clog2(R)`, register address width.
- `CW`, localparam `3*AW+7`, control word width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ctrl_word`  in  CW  fields, MSB first: `A[AW]`, `B[AW]`, `D[AW]`, `alu_op[4]`, `sh_op[3]`.
- `data_in`  in  W  external operand, used wherever `A` or `B` is 0.
- `in_valid`  in  1  `ctrl_word` and `data_in` are valid.
- `in_ready`  out  1  the block can accept the word this cycle.
- `data_out`  out  W  registered shifter result.
- `out_valid`  out  1  one-cycle pulse: `data_out` and `state_bits` are new.
- `state_bits`  out  4  registered flags `{V,N,Z,C}`.

## Operation
- Transfer occurs when `in_valid && in_ready` at a rising edge (the accept edge).
- On acceptance, stage S1 captures `A`, `B`, `D`, `alu_op`, `sh_op` and the two operands:
  - `opA = (A!=0) ? reg[A] : data_in`
  - `opB = (B!=0) ? reg[B] : data_in`
- ALU on the S1 operands, with `y` selected by `alu_op[2:1]`: 00 → 0, 01 → `opB`, 10 → `~opB`, 11 → all ones. `cin = alu_op[0]`.
  - `alu_op[3]=0`: result = `opA + y + cin`, W bits, with carry out.
  - `alu_op[3]=1`: `alu_op[2:1]` 00 → AND, 01 → OR, 10 → XOR, 11 → `~opA`.
- Flags are computed on the ALU result, before the shifter:
  - N = MSB; Z = (result == 0).
  - C = carry out, arithmetic only; otherwise 0.
  - V = (`opA[W-1]==y[W-1]`) && (`sum[W-1]!=opA[W-1]`), arithmetic only; otherwise 0.
- Shifter, `sh_op`: 000/100/111 → pass; 001 → shift left by 1, zero fill; 010 → logical shift right by 1; 011 → 0; 101 → rotate left; 110 → rotate right.
- Writeback: the shifter result is written to `reg[D]` when `D!=0`. A write to `D=0` is dropped, but `data_out`, flags and `out_valid` still update.
- Flags and `data_out` change only on completing operations; otherwise they hold.

## Timing
- Reset (asynchronous): all `reg[]` = 0, S1 empty, `data_out` = 0, `state_bits` = 0, `out_valid` = 0, `in_ready` = 1 once reset is deasserted.
- Latency: a word accepted at edge T0 produces `data_out`, `state_bits` and the register write at edge T1. `out_valid` is high for the cycle following T1.
- Throughput: one word per clock when there is no stall.
- Read-after-write hazard: the incoming word has `A` or `B` ≠ 0 equal to the `D` of the valid S1 word (with S1 `D`≠0).
- Same-edge read/write of a non-hazard register reads the pre-write value. This never occurs for hazards, because they are handled per Configuration.
- `in_ready` may depend combinationally on `ctrl_word`. The sequencer must not make `in_valid` depend on `in_ready`.
- Reset mid-operation discards the S1 word: no writeback and no `out_valid`.
- There is no output back-pressure; the consumer must take `data_out` on the `out_valid` cycle.

## Configuration
- `UP_FORWARD_EN` defined:
  - Hazards are resolved by bypass: the operand is taken from the current S1 shifter result.
  - `in_ready` is constantly 1 outside reset.
- `UP_FORWARD_EN` undefined:
  - On a hazard, `in_ready` = 0 for exactly one cycle, while S1 completes.
  - The word is accepted on the following edge with the updated register value.
  - Dependent words therefore issue every 2 cycles.

## Test plan
- Reset: assert `reset` mid-stream → all outputs 0 asynchronously. Afterwards, `A=1,B=1`, `alu_op=0010`, `D=0` → `data_out=0x00`, `state_bits=4'b0010`.
- Load: `data_in=0x5A`, `A=0`, `B=0`, `D=1`, `alu_op=0000`, `sh_op=000` → one cycle later `data_out=0x5A`, `state_bits=0000`, `out_valid` pulse, R1=0x5A.
- Overflow: R1=0x7F, `A=1`, `B=0`, `data_in=0x01`, `alu_op=0010` → `data_out=0x80`, `state_bits=4'b1100`. Then `alu_op=0100` with `A=1`, `B=0`, `data_in=0x7F` → `0x7F-0x7F-1`, i.e. `0xFF` with C=0.
- Shift: R2=0x81, `alu_op=0000`, `A=2`: `sh_op=101` → 0x03; `sh_op=110` → 0xC0; `sh_op=011` → 0x00 with N=1, Z=0, taken from the pre-shift value.
- Hazard: word 1 `D=3`, `data_in=0x03`, followed by word 2 `A=3,B=3`, `alu_op=0010`, `D=4`, presented back-to-back → word 2 yields 0x06 and R4=0x06.
  - With `UP_FORWARD_EN`: `in_ready` stays 1; results appear on consecutive cycles.
  - Without it: `in_ready` is low for 1 cycle; the results are 2 cycles apart.
- Write to R0: `D=0` with `data_in=0x11` and a pass operation → `out_valid` pulses with `data_out=0x11`. A following `A=0` read still returns `data_in`; no register changes.
